// File: rtl/mpf_vtp_csr_responder.sv
// CSR responder for the VTP translation block: feature header, mode/page-table
// registers, single-page invalidate handshake and hit/miss/fail statistics.
module mpf_vtp_csr_responder #(
  parameter int          N_CSR_IDX_BITS = 4,
  parameter logic [63:0] VTP_UUID_L     = 64'h0,
  parameter logic [63:0] VTP_UUID_H     = 64'h0,
  parameter int          STAT_CNT_WIDTH = 48
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_CSR_IDX_BITS-1:0] csr_req_idx,
  input  logic                      rd_req_en,
  input  logic                      wr_req_en,
  input  logic [63:0]               wr_data,
  input  logic [63:0]               dfh_value,
  output logic                      rd_rsp_valid,
  output logic [63:0]               rd_data,
  output logic                      vtp_enable,
  output logic [63:0]               pt_paddr,
  output logic                      inval_all,
  output logic                      inval_valid,
  output logic [63:0]               inval_vpn,
  input  logic                      inval_ready,
  input  logic                      stat_hit,
  input  logic                      stat_miss,
  input  logic                      stat_fail
);

  localparam logic [N_CSR_IDX_BITS-1:0] IDX_DFH    = N_CSR_IDX_BITS'(0);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_UUID_L = N_CSR_IDX_BITS'(1);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_UUID_H = N_CSR_IDX_BITS'(2);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_MODE   = N_CSR_IDX_BITS'(3);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_PT     = N_CSR_IDX_BITS'(4);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_INVAL  = N_CSR_IDX_BITS'(5);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_STATUS = N_CSR_IDX_BITS'(6);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_HITS   = N_CSR_IDX_BITS'(7);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_MISSES = N_CSR_IDX_BITS'(8);
  localparam logic [N_CSR_IDX_BITS-1:0] IDX_FAILS  = N_CSR_IDX_BITS'(9);

  logic                      rdRspValid_q, rdRspValid_d;
  logic [63:0]               rdData_q, rdData_d;
  logic                      vtpEnable_q, vtpEnable_d;
  logic [63:0]               ptPaddr_q, ptPaddr_d;
  logic                      invalAll_q, invalAll_d;
  logic                      invalValid_q, invalValid_d;
  logic [63:0]               invalVpn_q, invalVpn_d;
  logic                      overflow_q, overflow_d;
  logic [STAT_CNT_WIDTH-1:0] hitCnt_q, hitCnt_d;
  logic [STAT_CNT_WIDTH-1:0] missCnt_q, missCnt_d;
  logic [STAT_CNT_WIDTH-1:0] failCnt_q, failCnt_d;

  logic        wrMode, wrPt, wrInval, wrStatus, wrHits, wrMisses, wrFails;
  logic [63:0] rdMux;

  assign wrMode   = wr_req_en && (csr_req_idx == IDX_MODE);
  assign wrPt     = wr_req_en && (csr_req_idx == IDX_PT);
  assign wrInval  = wr_req_en && (csr_req_idx == IDX_INVAL);
  assign wrStatus = wr_req_en && (csr_req_idx == IDX_STATUS);
  assign wrHits   = wr_req_en && (csr_req_idx == IDX_HITS);
  assign wrMisses = wr_req_en && (csr_req_idx == IDX_MISSES);
  assign wrFails  = wr_req_en && (csr_req_idx == IDX_FAILS);

  // Reads see register state before any same-cycle write lands.
  always_comb begin
    rdMux = '0;
    case (csr_req_idx)
      IDX_DFH:    rdMux = dfh_value;
      IDX_UUID_L: rdMux = VTP_UUID_L;
      IDX_UUID_H: rdMux = VTP_UUID_H;
      IDX_MODE:   rdMux = {63'b0, vtpEnable_q};
      IDX_PT:     rdMux = ptPaddr_q;
      IDX_STATUS: rdMux = {62'b0, overflow_q, invalValid_q};
      IDX_HITS:   rdMux = 64'(hitCnt_q);
      IDX_MISSES: rdMux = 64'(missCnt_q);
      IDX_FAILS:  rdMux = 64'(failCnt_q);
      default:    rdMux = '0;
    endcase
  end

  always_comb begin
    rdRspValid_d = rd_req_en;
    rdData_d     = rd_req_en ? rdMux : 64'h0;
    vtpEnable_d  = wrMode ? wr_data[0] : vtpEnable_q;
    invalAll_d   = wrMode && wr_data[1];
    ptPaddr_d    = wrPt ? wr_data : ptPaddr_q;

    invalValid_d = invalValid_q;
    invalVpn_d   = invalVpn_q;
    overflow_d   = overflow_q;
    if (wrStatus && wr_data[1]) begin
      overflow_d = 1'b0;
    end
    if (invalValid_q && inval_ready) begin
      invalValid_d = 1'b0;
    end
    // A pending request (even one completing this cycle) blocks new loads.
    if (wrInval) begin
      if (invalValid_q) begin
        overflow_d = 1'b1;
      end else begin
        invalValid_d = 1'b1;
        invalVpn_d   = wr_data;
      end
    end

    hitCnt_d = hitCnt_q;
    if (wrHits) hitCnt_d = '0;
    else if (stat_hit) hitCnt_d = hitCnt_q + STAT_CNT_WIDTH'(1);

    missCnt_d = missCnt_q;
    if (wrMisses) missCnt_d = '0;
    else if (stat_miss) missCnt_d = missCnt_q + STAT_CNT_WIDTH'(1);

    failCnt_d = failCnt_q;
    if (wrFails) failCnt_d = '0;
    else if (stat_fail) failCnt_d = failCnt_q + STAT_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdRspValid_q <= 1'b0;
      rdData_q     <= '0;
      vtpEnable_q  <= 1'b0;
      ptPaddr_q    <= '0;
      invalAll_q   <= 1'b0;
      invalValid_q <= 1'b0;
      invalVpn_q   <= '0;
      overflow_q   <= 1'b0;
      hitCnt_q     <= '0;
      missCnt_q    <= '0;
      failCnt_q    <= '0;
    end else begin
      rdRspValid_q <= rdRspValid_d;
      rdData_q     <= rdData_d;
      vtpEnable_q  <= vtpEnable_d;
      ptPaddr_q    <= ptPaddr_d;
      invalAll_q   <= invalAll_d;
      invalValid_q <= invalValid_d;
      invalVpn_q   <= invalVpn_d;
      overflow_q   <= overflow_d;
      hitCnt_q     <= hitCnt_d;
      missCnt_q    <= missCnt_d;
      failCnt_q    <= failCnt_d;
    end
  end

  assign rd_rsp_valid = rdRspValid_q;
  assign rd_data      = rdData_q;
  assign vtp_enable   = vtpEnable_q;
  assign pt_paddr     = ptPaddr_q;
  assign inval_all    = invalAll_q;
  assign inval_valid  = invalValid_q;
  assign inval_vpn    = invalVpn_q;

endmodule
